// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the stack-machine calculator front end
// Holds the instruction header layout, opcode set and program-fetcher states.
package calc_pkg;

    localparam int DEF_INSTR_WIDTH = 8;
    localparam int OPC_MSB         = 7;
    localparam int OPC_LSB         = 2;
    localparam int NARGS_MSB       = 1;

    typedef enum logic [OPC_MSB-OPC_LSB:0] {
        HALT    = 6'd0,
        VARPUSH = 6'd1,
        EVAL    = 6'd2,
        IMDPUSH = 6'd3,
        POP     = 6'd4,
        ADD     = 6'd5,
        SUB     = 6'd6,
        MUL     = 6'd7
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        PUSH  = 3'd3,
        FIN   = 3'd4
    } fetch_state_e;

    function automatic logic opc_in_range(input logic [OPC_MSB-OPC_LSB:0] opc);
        return opc >= VARPUSH && opc <= MUL;
    endfunction

endpackage

// File: rtl/instr_hdr_decode.sv
// instr_hdr_decode: combinational split of an instruction header word
// Flags HALT (all-zero word), extracts the argument count and validates the opcode.
module instr_hdr_decode
    import calc_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0] word,
    output logic                   is_halt,
    output logic [NARGS_MSB:0]     nargs,
    output logic                   opc_valid
);

    assign is_halt   = word == '0;
    assign nargs     = word[NARGS_MSB:0];
    assign opc_valid = opc_in_range(word[OPC_MSB:OPC_LSB]);

endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: walks the program ROM and pushes every word into the executer FIFO
// Build with INSTR_FETCH_OPCHECK_EN to reject headers whose opcode is outside 1..7.
module instr_fetcher
    import calc_pkg::*;
#(
    parameter int INSTR_WIDTH     = DEF_INSTR_WIDTH,
    parameter int PROG_ADDR_WIDTH = 10,
    parameter int START_ADDR      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    output logic                       prog_rd,
    input  logic [INSTR_WIDTH-1:0]     prog_data,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [INSTR_WIDTH-1:0]     fifo_data
);

    localparam logic [PROG_ADDR_WIDTH-1:0] START_PC = PROG_ADDR_WIDTH'(START_ADDR);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_LATCH = LATCH;
    localparam logic [2:0] S_PUSH  = PUSH;
    localparam logic [2:0] S_FIN   = FIN;

    logic [2:0]                 state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [NARGS_MSB:0]         args_q, args_d;
    logic [INSTR_WIDTH-1:0]     word_q, word_d;
    logic                       halt_q, halt_d;
    logic                       err_q, err_d;
    logic                       hdr_halt, hdr_opc_ok, opc_reject;
    logic [NARGS_MSB:0]         hdr_nargs;

    instr_hdr_decode #(.INSTR_WIDTH(INSTR_WIDTH)) u_dec (
        .word      (prog_data),
        .is_halt   (hdr_halt),
        .nargs     (hdr_nargs),
        .opc_valid (hdr_opc_ok)
    );

`ifdef INSTR_FETCH_OPCHECK_EN
    assign opc_reject = !hdr_halt && !hdr_opc_ok;
`else
    logic unused_opc_ok;
    assign unused_opc_ok = hdr_opc_ok;
    assign opc_reject    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        args_d  = args_q;
        word_d  = word_q;
        halt_d  = halt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_PC;
                    args_d  = '0;
                    halt_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                word_d  = prog_data;
                pc_d    = pc_q + PROG_ADDR_WIDTH'(1);
                state_d = S_PUSH;
                if (args_q == '0) begin
                    halt_d = hdr_halt;
                    args_d = hdr_nargs;
                    if (opc_reject) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end
                end else begin
                    args_d = args_q - 1'b1;
                end
            end
            S_PUSH: begin
                // pc already advanced, so zero here means the top address was just pushed
                if (!fifo_full) begin
                    state_d = (halt_q || pc_q == '0) ? S_FIN : S_FETCH;
                    err_d   = !halt_q && pc_q == '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            args_q  <= '0;
            word_q  <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            args_q  <= args_d;
            word_q  <= word_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end

    assign busy      = state_q == S_FETCH || state_q == S_LATCH || state_q == S_PUSH;
    assign done      = state_q == S_FIN;
    assign err       = err_q;
    assign prog_addr = pc_q;
    assign prog_rd   = state_q == S_FETCH;
    assign fifo_wr   = state_q == S_PUSH && !fifo_full;
    assign fifo_data = word_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: directed checks of the program fetcher against hand-computed words
// Covers latency, zero arguments, backpressure, address wrap, mid-run reset and opcode check.
module tb_instr_fetcher;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0, fifo_full = 1'b0;
    logic       busy, done, err, prog_rd, fifo_wr;
    logic       busy2, done2, err2, prog_rd2, fifo_wr2;
    logic [9:0] prog_addr;
    logic [1:0] prog_addr2;
    logic [7:0] prog_data, prog_data2, fifo_data, fifo_data2;
    logic [7:0] rom [0:1023];
    logic [7:0] rom2 [0:3];
    logic [7:0] rd_q = 8'h00, rd2_q = 8'h00;
    logic [7:0] got[$], got2[$], q[$], e[$];
    int         cyc = 0, n_rd = 0, first_wr = -1, viol = 0, t0 = 0, dur = 0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    instr_fetcher dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data)
    );

    instr_fetcher #(.PROG_ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .err(err2),
        .prog_addr(prog_addr2), .prog_rd(prog_rd2), .prog_data(prog_data2),
        .fifo_full(1'b0), .fifo_wr(fifo_wr2), .fifo_data(fifo_data2)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prog_rd) rd_q <= rom[prog_addr];
        if (prog_rd2) rd2_q <= rom2[prog_addr2];
    end
    assign prog_data  = rd_q;
    assign prog_data2 = rd2_q;

    always @(negedge clk) begin
        if (fifo_wr) begin
            got.push_back(fifo_data);
            if (first_wr < 0) first_wr = cyc;
        end
        if (fifo_wr && fifo_full) viol++;
        if (prog_rd) n_rd++;
        if (fifo_wr2) got2.push_back(fifo_data2);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] act[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            check($sformatf("%s[%0d]", tag, i), act[i], exp[i]);
    endtask

    task automatic load(input logic [7:0] p[$]);
        for (int i = 0; i < 1024; i++) rom[i] = 8'hA5;
        for (int i = 0; i < p.size(); i++) rom[i] = p[i];
        got.delete();
        n_rd = 0;
        viol = 0;
    endtask

    task automatic pulse_start();
        t0       = cyc;
        first_wr = -1;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int d);
        for (int i = 0; i < 300 && !done; i++) tick(1);
        d = cyc - t0;
        check({tag, "_done"}, 32'(done), 1);
    endtask

    initial begin
        tick(3);
        check("reset_outs", {busy, done, err, prog_rd, fifo_wr, prog_addr, fifo_data}, 0);
        check("reset_outs2", {busy2, done2, err2, prog_rd2, fifo_wr2, prog_addr2, fifo_data2}, 0);
        reset = 1'b0;
        tick(2);

        q = '{8'h0D, 8'h05, 8'h0D, 8'h07, 8'h14, 8'h00};
        load(q);
        pulse_start();
        check("t1_busy", 32'(busy), 1);
        wait_done("t1", dur);
        check("t1_err", 32'(err), 0);
        check("t1_first_wr", first_wr - t0, 3);
        check("t1_dur", dur, 19);
        check_seq("t1_seq", got, q);
        tick(5);
        check("t1_reads", n_rd, 6);
        check("t1_no_extra_wr", got.size(), 6);
        check("t1_done_held", 32'(done), 1);

        q = '{8'h0D, 8'h00, 8'h0D, 8'h00, 8'h00};
        load(q);
        pulse_start();
        wait_done("t2", dur);
        check("t2_dur", dur, 16);
        check("t2_err", 32'(err), 0);
        check_seq("t2_seq", got, q);

        q = '{8'h0D, 8'h05, 8'h0D, 8'h07, 8'h14, 8'h00};
        load(q);
        pulse_start();
        tick(4);
        fifo_full = 1'b1;
        tick(11);
        fifo_full = 1'b0;
        wait_done("t3", dur);
        check("t3_dur", dur, 29);
        check("t3_wr_while_full", viol, 0);
        check_seq("t3_seq", got, q);

        rom2[0] = 8'h0D; rom2[1] = 8'h01; rom2[2] = 8'h0D; rom2[3] = 8'h02;
        got2.delete();
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        for (int i = 0; i < 100 && !done2; i++) tick(1);
        check("t4_done", 32'(done2), 1);
        check("t4_err", 32'(err2), 1);
        e = '{8'h0D, 8'h01, 8'h0D, 8'h02};
        check_seq("t4_seq", got2, e);

        q = '{8'h0D, 8'h05, 8'h0D, 8'h07, 8'h14, 8'h00};
        load(q);
        pulse_start();
        tick(8);
        check("t5_in_push3", 32'(fifo_wr), 1);
        reset = 1'b1;
        #1;
        check("t5_reset_outs", {busy, done, err, prog_rd, fifo_wr, prog_addr, fifo_data}, 0);
        tick(1);
        reset = 1'b0;
        tick(4);
        check("t5_writes_before_reset", got.size(), 2);
        check("t5_reads_before_reset", n_rd, 3);
        load(q);
        pulse_start();
        wait_done("t5", dur);
        check("t5_err", 32'(err), 0);
        check_seq("t5_seq", got, q);

        q = '{8'h0D, 8'h05, 8'hFC, 8'h00};
        load(q);
        pulse_start();
        wait_done("t6", dur);
`ifdef INSTR_FETCH_OPCHECK_EN
        e = '{8'h0D, 8'h05};
        check("t6_err", 32'(err), 1);
`else
        e = '{8'h0D, 8'h05, 8'hFC, 8'h00};
        check("t6_err", 32'(err), 0);
`endif
        check_seq("t6_seq", got, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Program-fetch stage that sits directly upstream of the instruction FIFO feeding the stack-machine executer.
- On `start`, walks a synchronous program ROM from `START_ADDR` and pushes every instruction word into the FIFO, honouring `fifo_full`.
- Each header word (`[7:2]` opcode, `[1:0]` arg count) is tracked so that argument words are never mistaken for HALT (header == 0).
- Stops after pushing HALT.

Parameters:
- INSTR_WIDTH, 8, instruction/argument word width in bits.
- PROG_ADDR_WIDTH, 10, program ROM address width.
- START_ADDR, 0, first program address fetched after start.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a fetch run when not busy.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  high after HALT is pushed or on error; held until next accepted start.
- err  output  1  high with done when the run ended abnormally; held until next accepted start.
- prog_addr  output  PROG_ADDR_WIDTH  ROM address.
- prog_rd  output  1  ROM read strobe; data valid on prog_data exactly one cycle later.
- prog_data  input  INSTR_WIDTH  ROM read data.
- fifo_full  input  1  FIFO cannot accept a write this cycle.
- fifo_wr  output  1  one-cycle write strobe.
- fifo_data  output  INSTR_WIDTH  word written; stable while fifo_wr is high.

Behaviour:
- Reset: state IDLE; pc=START_ADDR; args_left=0; busy, done, err, prog_rd, fifo_wr = 0; prog_addr=START_ADDR; fifo_data=0. Reset mid-run aborts immediately and produces no further ROM reads or FIFO writes.
- FSM states: IDLE, FETCH, LATCH, PUSH, FIN.
- IDLE: on start, clear done/err, load pc=START_ADDR, go to FETCH. Start in any other state is ignored, except FIN, which behaves like IDLE.
- FETCH: prog_rd=1, prog_addr=pc, go to LATCH.
- LATCH: capture prog_data into word register, then classify:
  - If args_left==0 (header): word==0 means HALT flag; otherwise args_left=word[1:0].
  - Else (argument word): args_left-=1.
  - Then pc+=1 and go to PUSH.
- PUSH: if fifo_full, hold with fifo_wr=0. Otherwise fifo_wr=1 for exactly one cycle with fifo_data=word. Next state:
  - FIN if HALT;
  - FIN with err=1 if pc wrapped to 0 (program ran past the top of ROM);
  - else FETCH.
- FIN: busy=0, done=1.
- Latency: first fifo_wr 3 cycles after accepted start (no backpressure). Steady state is one word per 3 cycles; each full cycle adds 1 cycle.
- A word value of 0 in argument position is pushed as data, never treated as HALT.
- fifo_wr is never asserted while fifo_full is high; the writer checks fifo_full in the same cycle it would write.
- pc wraps modulo 2^PROG_ADDR_WIDTH. The wrap is detected after the increment that produces 0 from all-ones; the word at the top address is still pushed.

Optional Feature:
- Macro: INSTR_FETCH_OPCHECK_EN.
- When defined: any header with a nonzero word whose opcode `[7:2]` is outside 1..7 is not pushed; the block goes to FIN with err=1.
- When undefined: all headers pass through unchecked, and err is set only by address wrap.

Decomposition:
- Shared package calc_pkg holds:
  - INSTR_WIDTH default;
  - opcode enum: HALT=0, VARPUSH=1, EVAL=2, IMDPUSH=3, POP=4, ADD=5, SUB=6, MUL=7;
  - header field slice constants (OPC_MSB=7, OPC_LSB=2, NARGS_MSB=1);
  - fetcher state enum.
- One combinational sub-module, instr_hdr_decode: word in; is_halt, nargs, opc_valid out.

Test Plan:
- ROM 0x0D,0x05,0x0D,0x07,0x14,0x00; start; fifo_full=0 -> fifo_data sequence 0x0D,0x05,0x0D,0x07,0x14,0x00; done=1, err=0; no further prog_rd; first fifo_wr 3 cycles after start.
- ROM 0x0D,0x00,0x0D,0x00,0x00 -> five words pushed, including both zero arguments; done only after the fifth write.
- Same program as case 1, fifo_full held high for 10 cycles during the 2nd push -> no fifo_wr while full; sequence intact; total time +10 cycles.
- PROG_ADDR_WIDTH=2, ROM 0x0D,0x01,0x0D,0x02 (no HALT) -> 4 words pushed, then done=1, err=1.
- Reset asserted in the 3rd PUSH -> all outputs 0 immediately; a new start replays from word 0x0D at START_ADDR.
- INSTR_FETCH_OPCHECK_EN defined, ROM 0x0D,0x05,0xFC -> 2 words pushed, 0xFC not pushed, done=1, err=1. Undefined: 0xFC is pushed and its 0 args are honoured.
